// File: rtl/bf16_pkg.sv
// Shared bf16 field widths and class-flag bit positions.
package bf16_pkg;
   localparam int NUM_WIDTH  = 16;
   localparam int EXP_WIDTH  = 8;
   localparam int SIG_WIDTH  = 7;
   localparam int FLAG_WIDTH = 4;

   localparam int FLAG_NAN  = 3;
   localparam int FLAG_ZERO = 2;
   localparam int FLAG_INF  = 1;
   localparam int FLAG_NORM = 0;

   localparam logic [EXP_WIDTH-1:0] EXP_ALL_ONES = '1;
endpackage

// File: rtl/bf16_class.sv
// Combinational bf16 classifier: splits the word and raises exactly one class flag.
module bf16_class
   import bf16_pkg::*;
#(
   parameter int EW = EXP_WIDTH,
   parameter int SW = SIG_WIDTH
) (
   input  logic [EW+SW:0]         word_i,
   output logic [FLAG_WIDTH-1:0]  flag_o,
   output logic                   sign_o,
   output logic [EW-1:0]          exp_o,
   output logic [SW-1:0]          sig_o
);
   logic e_ones, e_zero, s_ones, s_zero;

   assign sign_o = word_i[EW+SW];
   assign exp_o  = word_i[EW+SW-1:SW];
   assign sig_o  = word_i[SW-1:0];

   assign e_ones = &exp_o;
   assign e_zero = ~|exp_o;
   assign s_ones = &sig_o;
   assign s_zero = ~|sig_o;

   // Subnormals deliberately land in the norm class.
   always_comb begin
      flag_o = '0;
      if (e_ones && s_ones)       flag_o[FLAG_NAN]  = 1'b1;
      else if (e_ones)            flag_o[FLAG_INF]  = 1'b1;
      else if (e_zero && s_zero)  flag_o[FLAG_ZERO] = 1'b1;
      else                        flag_o[FLAG_NORM] = 1'b1;
   end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick starting at the pointer; pointer moves past the winner on advance.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [N-1:0]  req_i,
   input  logic          adv_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW:0]   cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
         if (!any_o && req_i[cand[IW-1:0]]) begin
            any_o                   = 1'b1;
            idx_o                   = cand[IW-1:0];
            grant_o[cand[IW-1:0]]   = 1'b1;
         end
      end
   end

   // Explicit wrap so non-power-of-two N never points past the last requester.
   assign ptr_d = (idx_o == IW'(N-1)) ? '0 : idx_o + 1'b1;

   always_ff @(posedge clk_i) begin
      if (!rst_ni)    ptr_q <= '0;
      else if (adv_i) ptr_q <= ptr_d;
   end
endmodule

// File: rtl/bf16_class_arb.sv
// Round-robin shared bf16 classifier with a single-entry result stage and per-class counters.
module bf16_class_arb
   import bf16_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int NUM_WIDTH  = 16,
   parameter int EXP_WIDTH  = 8,
   parameter int SIG_WIDTH  = 7,
   parameter int FLAG_WIDTH = 4,
   parameter int CNT_WIDTH  = 16,
   localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   input  logic [NUM_REQ*NUM_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic                         o_res_valid,
   input  logic                         i_res_ready,
   output logic [ID_WIDTH-1:0]          o_res_id,
   output logic [FLAG_WIDTH-1:0]        o_res_flag,
   output logic                         o_res_sign,
   output logic [EXP_WIDTH-1:0]         o_res_exp,
   output logic [SIG_WIDTH-1:0]         o_res_sig,
   input  logic                         i_cnt_clr,
   output logic [CNT_WIDTH-1:0]         o_cnt_nan,
   output logic [CNT_WIDTH-1:0]         o_cnt_zero,
   output logic [CNT_WIDTH-1:0]         o_cnt_inf,
   output logic [CNT_WIDTH-1:0]         o_cnt_norm
);
   logic                  accept_en, accept, any_req;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic [NUM_WIDTH-1:0]  sel_word;
   logic [FLAG_WIDTH-1:0] flag_d, flag_q;
   logic                  sign_d, sign_q, valid_q;
   logic [EXP_WIDTH-1:0]  exp_d, exp_q;
   logic [SIG_WIDTH-1:0]  sig_d, sig_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [CNT_WIDTH-1:0]  cnt_q [FLAG_WIDTH];

   assign accept_en   = ~valid_q | i_res_ready;
   assign o_req_ready = i_rst_n ? (grant & {NUM_REQ{accept_en}}) : '0;
   assign accept      = i_rst_n & any_req & accept_en;
   assign sel_word    = i_req_data[grant_idx*NUM_WIDTH +: NUM_WIDTH];

   rr_arbiter #(.N(NUM_REQ), .IW(ID_WIDTH)) u_arb (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .req_i   (i_req_valid),
      .adv_i   (accept),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .any_o   (any_req)
   );

   bf16_class #(.EW(EXP_WIDTH), .SW(SIG_WIDTH)) u_class (
      .word_i (sel_word),
      .flag_o (flag_d),
      .sign_o (sign_d),
      .exp_o  (exp_d),
      .sig_o  (sig_d)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         id_q    <= '0;
         flag_q  <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         sig_q   <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         id_q    <= grant_idx;
         flag_q  <= flag_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         sig_q   <= sig_d;
      end else if (i_res_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Clear wins over a same-cycle increment; counters stick at all-ones.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < FLAG_WIDTH; k++) begin
         if (!i_rst_n || i_cnt_clr)                    cnt_q[k] <= '0;
         else if (accept && flag_d[k] && !(&cnt_q[k])) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
   end

   assign o_res_valid = valid_q;
   assign o_res_id    = id_q;
   assign o_res_flag  = flag_q;
   assign o_res_sign  = sign_q;
   assign o_res_exp   = exp_q;
   assign o_res_sig   = sig_q;
   assign o_cnt_nan   = cnt_q[FLAG_NAN];
   assign o_cnt_zero  = cnt_q[FLAG_ZERO];
   assign o_cnt_inf   = cnt_q[FLAG_INF];
   assign o_cnt_norm  = cnt_q[FLAG_NORM];
endmodule

// File: doc/bf16_class_arb.md
Name: bf16_class_arb

Overview:
- Shares one bf16 classification datapath between NUM_REQ requesters using round-robin arbitration with valid/ready handshakes on both sides.
- Registers the classified result (flag, sign, exp, sig) with the requester ID into a single-entry output stage.
- Keeps saturating per-class event counters for KAN input-range monitoring.
- Sits between the activation input buffers and the spline-evaluation front end.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- NUM_WIDTH, 16, bf16 word width.
- EXP_WIDTH, 8, exponent width.
- SIG_WIDTH, 7, significand width.
- FLAG_WIDTH, 4, class flag width, encoded {nan, zero, inf, norm}.
- CNT_WIDTH, 16, width of each event counter.
- ID_WIDTH, $clog2(NUM_REQ), derived localparam; requester ID width.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester valid.
- i_req_data  in  NUM_REQ*NUM_WIDTH  requester k's bf16 word in bits [k*NUM_WIDTH +: NUM_WIDTH].
- o_req_ready  out  NUM_REQ  per-requester ready; one-hot or zero.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  downstream ready.
- o_res_id  out  ID_WIDTH  index of the requester that produced this result.
- o_res_flag  out  FLAG_WIDTH  {nan, zero, inf, norm}.
- o_res_sign  out  1  sign bit.
- o_res_exp  out  EXP_WIDTH  raw exponent field.
- o_res_sig  out  SIG_WIDTH  raw significand field.
- i_cnt_clr  in  1  synchronous clear of all counters.
- o_cnt_nan, o_cnt_zero, o_cnt_inf, o_cnt_norm  out  CNT_WIDTH each  accepted-word count per class.

Behaviour:
- Reset (i_rst_n=0 at an edge) forces: o_res_valid=0, o_res_id/flag/sign/exp/sig=0, rr pointer=0, all counters=0. Reset mid-transfer drops the held result without delivering it.
- o_req_ready is combinational; it must be 0 while i_rst_n=0.
- Slot free: accept_en = ~o_res_valid | i_res_ready. This is a combinational path from i_res_ready to o_req_ready.
- Grant: scan requesters in order ptr, ptr+1, ..., wrapping modulo NUM_REQ; grant the first one with i_req_valid set. o_req_ready = grant & {NUM_REQ{accept_en}}.
- Accept: the granted requester's valid and ready are both high at the edge.
- On accept:
  - register the classified fields and the grant index.
  - set o_res_valid=1.
  - ptr <= (granted index + 1) mod NUM_REQ. When NUM_REQ is not a power of two, the wrap is an explicit compare, not a natural overflow.
- No accept but i_res_ready=1: o_res_valid <= 0.
- Latency: 1 cycle from accept to o_res_valid.
- Throughput: one word per cycle while i_res_ready=1. Accept and drain in the same cycle are allowed, with no bubble.
- Stability: while o_res_valid=1 and i_res_ready=0, all o_res_* outputs hold and the pointer does not move.
- No request pending: pointer holds.
- Classification (combinational, on the selected word): E=exp field, S=sig field.
  - nan = (E all ones) and (S all ones).
  - inf = (E all ones) and (S not all ones).
  - zero = (E==0) and (S==0), either sign.
  - norm = none of the above; this includes subnormals.
  - Exactly one flag bit is set.
- Counters:
  - On each accept, increment the counter matching the flag.
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - i_cnt_clr has priority over an increment in the same cycle: the result is 0.

Decomposition:
- Shared package bf16_pkg:
  - width constants (NUM_WIDTH, EXP_WIDTH, SIG_WIDTH, FLAG_WIDTH).
  - flag bit indices FLAG_NAN=3, FLAG_ZERO=2, FLAG_INF=1, FLAG_NORM=0.
  - EXP_ALL_ONES constant.
- Sub-module: instantiate the team's existing bf16_class classifier once, on the muxed word.
- Sub-module: rr_arbiter (round-robin priority pick plus pointer), reusable by other shared units.

Test Plan:
- Reset: hold i_rst_n=0 with all i_req_valid=1 -> o_req_ready=0, o_res_valid=0, all counters 0; after release, first grant goes to requester 0.
- Fairness: NUM_REQ=4, all valid continuously, i_res_ready=1 -> o_res_id sequence 0,1,2,3,0,1, with o_res_valid high every cycle after the first accept.
- Classes: requester 2 sends 0x0000, 0x8000, 0x7F80, 0xFFFF, 0x3F80 -> flags 0100, 0100, 0010, 1000, 0001; o_cnt_zero=2, o_cnt_inf=1, o_cnt_nan=1, o_cnt_norm=1.
- Backpressure: i_res_ready=0 for 5 cycles with a result held -> o_req_ready=0, outputs stable; raising i_res_ready gives a same-cycle drain and new accept.
- Skip/wrap: only requesters 3 and 1 valid, ptr=2 -> grants 3 then 1, then 3 again.
- Saturation/clear: CNT_WIDTH=4, 17 norm words -> o_cnt_norm=15; i_cnt_clr asserted in the same cycle as an accept -> 0 next cycle.
